// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the tdm_mux channel multiplexer:
// mode encoding and channel-index width helper.
package tdm_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_mux_rr_pick.sv
// Round-robin picker: first valid channel at or after ptr, wrapping to 0.
// The vector is doubled so the wrapped search becomes a single priority encode.
module tdm_mux_rr_pick
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_CH-1:0] dbl;

  always_comb begin
    dbl = {in_valid, in_valid};
    // Drop everything below ptr in the lower copy; the upper copy covers the wrap.
    for (int i = 0; i < 2*N_CH; i++)
      if (i < int'(ptr)) dbl[i] = 1'b0;
    found = |in_valid;
    idx   = '0;
    for (int i = 2*N_CH-1; i >= 0; i--)
      if (dbl[i]) idx = (i >= N_CH) ? SEL_W'(i - N_CH) : SEL_W'(i);
  end

endmodule

// File: rtl/tdm_mux.sv
// Registered N:1 time-division multiplexer with valid/ready handshake,
// manual channel select and round-robin scan modes.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
);

  logic [SEL_W-1:0]        ptr;
  logic [SEL_W-1:0]        scan_ch;
  logic                    scan_found;
  logic [SEL_W-1:0]        ch;
  logic                    sel_ok;
  logic                    cand_ok;
  logic                    load;
  logic [(1<<SEL_W)-1:0]   valid_pad;

  tdm_mux_rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .found    (scan_found),
    .idx      (scan_ch)
  );

  always_comb begin
    // Zero-padded so an out-of-range manual select reads as not valid.
    valid_pad             = '0;
    valid_pad[N_CH-1:0]   = in_valid;
    sel_ok                = ({1'b0, sel_in} < (SEL_W+1)'(N_CH));
    if (mode == MODE_MANUAL) begin
      ch      = sel_in;
      cand_ok = sel_ok && valid_pad[sel_in];
    end else begin
      ch      = scan_ch;
      cand_ok = scan_found;
    end
    load     = !rst && (!out_valid || out_ready) && cand_ok;
    in_ready = '0;
    for (int c = 0; c < N_CH; c++)
      in_ready[c] = load && (ch == SEL_W'(c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      sel_err <= (mode == MODE_MANUAL) && !sel_ok;
      if (load) begin
        out_data  <= in_data[int'(ch)*W +: W];
        out_ch    <= ch;
        out_valid <= 1'b1;
        if (mode == MODE_SCAN)
          ptr <= (ch == SEL_W'(N_CH-1)) ? '0 : ch + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: directed vector table, hand sequences for reset,
// backpressure and select errors, then random traffic against a reference model.
module tb_tdm_mux;
  import tdm_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_valid = '0;
  logic        mode = MODE_MANUAL;
  logic [2:0]  sel_in = '0;
  logic        out_ready = 1'b0;

  logic [7:0] rdy8, od8, od6;
  logic [5:0] rdy6;
  logic [2:0] oc8, oc6;
  logic       ov8, ov6, err8, err6;
  logic [7:0] rdy8_s, rdy6_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdm_mux #(.N_CH(8), .W(8)) u8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy8),
    .mode(mode), .sel_in(sel_in), .out_data(od8), .out_ch(oc8), .out_valid(ov8),
    .out_ready(out_ready), .sel_err(err8)
  );

  tdm_mux #(.N_CH(6), .W(8)) u6 (
    .clk(clk), .rst(rst), .in_data(in_data[47:0]), .in_valid(in_valid[5:0]), .in_ready(rdy6),
    .mode(mode), .sel_in(sel_in), .out_data(od6), .out_ch(oc6), .out_valid(ov6),
    .out_ready(out_ready), .sel_err(err6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register contents plus scan pointer.
  typedef struct {
    logic       v;
    logic [7:0] d;
    int         ch;
    int         ptr;
    logic       err;
  } mst_t;

  mst_t m8, m6;

  function automatic void mpick(input int n, input mst_t s, output logic ld, output int ch);
    logic ok;
    ok = 1'b0;
    ch = 0;
    if (mode == MODE_MANUAL) begin
      ch = int'(sel_in);
      ok = (ch < n) && in_valid[ch];
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (s.ptr + k) % n;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          ch = c;
        end
      end
    end
    ld = (!s.v || out_ready) && ok;
  endfunction

  function automatic mst_t mstep(input int n, input mst_t s);
    mst_t r;
    logic ld;
    int   ch;
    r = s;
    mpick(n, s, ld, ch);
    r.err = (mode == MODE_MANUAL) && (int'(sel_in) >= n);
    if (ld) begin
      r.v  = 1'b1;
      r.d  = in_data[ch*8 +: 8];
      r.ch = ch;
      if (mode == MODE_SCAN) r.ptr = (ch + 1) % n;
    end else if (out_ready) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [7:0] mready(input int n, input mst_t s);
    logic ld;
    int   ch;
    mpick(n, s, ld, ch);
    return ld ? (8'd1 << ch) : 8'd0;
  endfunction

  task automatic mreset();
    m8 = '{v: 1'b0, d: 8'h00, ch: 0, ptr: 0, err: 1'b0};
    m6 = '{v: 1'b0, d: 8'h00, ch: 0, ptr: 0, err: 1'b0};
  endtask

  task automatic chk_out();
    chk("out_valid8", 64'(ov8),  64'(m8.v));
    chk("out_data8",  64'(od8),  64'(m8.d));
    chk("out_ch8",    64'(oc8),  64'(m8.ch));
    chk("sel_err8",   64'(err8), 64'(m8.err));
    chk("out_valid6", 64'(ov6),  64'(m6.v));
    chk("out_data6",  64'(od6),  64'(m6.d));
    chk("out_ch6",    64'(oc6),  64'(m6.ch));
    chk("sel_err6",   64'(err6), 64'(m6.err));
  endtask

  // One clock: grants checked mid-cycle, registered outputs just after the edge.
  task automatic tick();
    logic [7:0] e8, e6;
    @(negedge clk);
    e8 = rst ? 8'h00 : mready(8, m8);
    e6 = rst ? 8'h00 : mready(6, m6);
    rdy8_s = rdy8;
    rdy6_s = {2'b00, rdy6};
    chk("in_ready8", 64'(rdy8_s), 64'(e8));
    chk("in_ready6", 64'(rdy6_s), 64'(e6));
    @(posedge clk);
    if (rst) mreset();
    else begin
      m8 = mstep(8, m8);
      m6 = mstep(6, m6);
    end
    #1;
    chk_out();
  endtask

  typedef struct {
    logic        md;
    logic [2:0]  sel;
    logic [7:0]  vld;
    logic [63:0] data;
    logic [7:0]  e_rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic [2:0]  e_ch;
  } vec_t;

  vec_t tbl[11];
  localparam logic [63:0] DINC = 64'h1716_1514_1312_1110;
  localparam logic [63:0] DA5  = 64'h0000_A500_0000_0000;

  initial begin
    tbl[0]  = '{MODE_MANUAL, 3'd5, 8'h20, DA5,  8'h20, 1'b1, 8'hA5, 3'd5};
    tbl[1]  = '{MODE_MANUAL, 3'd3, 8'h20, DA5,  8'h00, 1'b0, 8'hA5, 3'd5};
    tbl[2]  = '{MODE_MANUAL, 3'd0, 8'hFF, DINC, 8'h01, 1'b1, 8'h10, 3'd0};
    tbl[3]  = '{MODE_MANUAL, 3'd7, 8'h80, DINC, 8'h80, 1'b1, 8'h17, 3'd7};
    tbl[4]  = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h04, 1'b1, 8'h12, 3'd2};
    tbl[5]  = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h80, 1'b1, 8'h17, 3'd7};
    tbl[6]  = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h04, 1'b1, 8'h12, 3'd2};
    tbl[7]  = '{MODE_SCAN,   3'd0, 8'h00, DINC, 8'h00, 1'b0, 8'h12, 3'd2};
    tbl[8]  = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h80, 1'b1, 8'h17, 3'd7};
    tbl[9]  = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h04, 1'b1, 8'h12, 3'd2};
    tbl[10] = '{MODE_SCAN,   3'd0, 8'h84, DINC, 8'h80, 1'b1, 8'h17, 3'd7};

    // Power-on reset
    mreset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_in_ready",  64'(rdy8), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Directed table, downstream always ready
    foreach (tbl[i]) begin
      mode = tbl[i].md; sel_in = tbl[i].sel; in_valid = tbl[i].vld;
      in_data = tbl[i].data; out_ready = 1'b1;
      tick();
      chk($sformatf("tbl%0d_rdy", i), 64'(rdy8_s), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_v",   i), 64'(ov8),    64'(tbl[i].e_v));
      chk($sformatf("tbl%0d_d",   i), 64'(od8),    64'(tbl[i].e_d));
      chk($sformatf("tbl%0d_ch",  i), 64'(oc8),    64'(tbl[i].e_ch));
    end

    // Reset while a word is held under backpressure
    mode = MODE_SCAN; in_valid = 8'hFF; in_data = DINC; out_ready = 1'b0;
    tick();
    tick();
    chk("held_before_rst", 64'(ov8), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_v",   64'(ov8),  64'd0);
    chk("midrst_d",   64'(od8),  64'd0);
    chk("midrst_ch",  64'(oc8),  64'd0);
    chk("midrst_err", 64'(err8), 64'd0);
    chk("midrst_rdy", 64'(rdy8), 64'd0);
    chk("midrst_v6",  64'(ov6),  64'd0);
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-rate scan from channel 0
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("scan%0d_v",  k), 64'(ov8), 64'd1);
      chk($sformatf("scan%0d_ch", k), 64'(oc8), 64'(k % 8));
      chk($sformatf("scan%0d_d",  k), 64'(od8), 64'(8'h10 + k % 8));
    end

    // Backpressure hold, then pop-and-load in one cycle
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp%0d_rdy", k), 64'(rdy8_s), 64'd0);
      chk($sformatf("bp%0d_ch",  k), 64'(oc8),    64'd1);
      chk($sformatf("bp%0d_d",   k), 64'(od8),    64'h11);
      chk($sformatf("bp%0d_v",   k), 64'(ov8),    64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_pop_rdy", 64'(rdy8_s), 64'h04);
    chk("bp_pop_ch",  64'(oc8),    64'd2);
    chk("bp_pop_v",   64'(ov8),    64'd1);

    // Out-of-range manual select on the 6-channel instance
    mode = MODE_MANUAL; sel_in = 3'd1; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; sel_in = 3'd7;
    tick();
    chk("err6_rdy", 64'(rdy6_s), 64'd0);
    chk("err6_err", 64'(err6),   64'd1);
    chk("err6_v",   64'(ov6),    64'd1);
    chk("err6_ch",  64'(oc6),    64'd1);
    sel_in = 3'd0;
    tick();
    chk("err6_pulse_end", 64'(err6), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel_in    = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
